vga_module: RTL and testbench

VGA_MODULE -- requirements
Module: vga_module

---
 rtl/vga_module.sv | 117 +++++++++++
 tb/tb_vga_module.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vga_module.sv
// 640x480@60 VGA timing generator driving a static eight-bar colour test pattern.
// Counters advance once per pixel; every output is registered one iBusClk behind them.
`timescale 1ns/1ps
module vga_module #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       iBusClk,
    input  logic       iRstN,
    output logic [3:0] oRed,
    output logic [3:0] oGreen,
    output logic [3:0] oBlue,
    output logic       oHs,
    output logic       oVs
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT    = 10'(H_VIS);
    localparam logic [9:0] V_ACT    = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] BAR_W    = 10'(H_VIS / 8);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hCnt_q, hCnt_d;
    logic [9:0]       vCnt_q, vCnt_d;
    logic [3:0]       red_q, red_d;
    logic [3:0]       green_q, green_d;
    logic [3:0]       blue_q, blue_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             pixEn;
    logic             active;
    logic [9:0]       barIdx;

    always_comb begin
        pixEn  = (div_q == DIV_LAST);
        div_d  = pixEn ? '0 : div_q + 1'b1;
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (pixEn) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 10'd1;
            end else begin
                hCnt_d = hCnt_q + 10'd1;
            end
        end
    end

    // Colour and sync are decoded from the counters as they stand before this edge.
    always_comb begin
        active  = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
        barIdx  = hCnt_q / BAR_W;
        hs_d    = !((hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST));
        vs_d    = !((vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST));
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
        if (active) begin
            case (barIdx)
                10'd0:   begin red_d = 4'hF; green_d = 4'hF; blue_d = 4'hF; end
                10'd1:   begin red_d = 4'hF; green_d = 4'hF; blue_d = 4'h0; end
                10'd2:   begin red_d = 4'h0; green_d = 4'hF; blue_d = 4'hF; end
                10'd3:   begin red_d = 4'h0; green_d = 4'hF; blue_d = 4'h0; end
                10'd4:   begin red_d = 4'hF; green_d = 4'h0; blue_d = 4'hF; end
                10'd5:   begin red_d = 4'hF; green_d = 4'h0; blue_d = 4'h0; end
                10'd6:   begin red_d = 4'h0; green_d = 4'h0; blue_d = 4'hF; end
                default: begin red_d = 4'h0; green_d = 4'h0; blue_d = 4'h0; end
            endcase
        end
    end

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            div_q   <= '0;
            hCnt_q  <= '0;
            vCnt_q  <= '0;
            red_q   <= 4'h0;
            green_q <= 4'h0;
            blue_q  <= 4'h0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            hCnt_q  <= hCnt_d;
            vCnt_q  <= vCnt_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign oRed   = red_q;
    assign oGreen = green_q;
    assign oBlue  = blue_q;
    assign oHs    = hs_q;
    assign oVs    = vs_q;

endmodule

// File: tb/tb_vga_module.sv
// Directed bench for vga_module: default horizontal timing, shortened vertical timing
// (4 visible lines, sync on lines 6-7, 10-line frame) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_module;

    logic       iBusClk;
    logic       iRstN;
    logic [3:0] oRed;
    logic [3:0] oGreen;
    logic [3:0] oBlue;
    logic       oHs;
    logic       oVs;

    int checkCount;
    int errorCount;
    int curEdge;

    vga_module #(
        .CLK_DIV(4),
        .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VIS(4),   .V_FP(2),  .V_SYNC(2),  .V_BP(2)
    ) dut (
        .iBusClk(iBusClk),
        .iRstN  (iRstN),
        .oRed   (oRed),
        .oGreen (oGreen),
        .oBlue  (oBlue),
        .oHs    (oHs),
        .oVs    (oVs)
    );

    initial begin
        iBusClk = 1'b0;
        forever #5 iBusClk = ~iBusClk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Holds reset low for lowTime, checking the outputs dropped without a clock edge.
    task automatic applyStimulus(input int lowTime);
        iRstN = 1'b0;
        #1;
        checkOutput("rst_rgb", {20'd0, oRed, oGreen, oBlue}, 32'h000);
        checkOutput("rst_sync", {30'd0, oHs, oVs}, 32'h3);
        #(lowTime - 1);
        iRstN   = 1'b1;
        curEdge = 0;
    endtask

    task automatic runToEdge(input int target);
        while (curEdge < target) begin
            @(posedge iBusClk);
            curEdge++;
        end
        #1;
    endtask

    task automatic checkRgb(input string tag, input int edgeNum, input logic [11:0] expRgb);
        runToEdge(edgeNum);
        checkOutput(tag, {20'd0, oRed, oGreen, oBlue}, {20'd0, expRgb});
    endtask

    task automatic checkSync(input string tag, input int edgeNum, input logic [1:0] expSync);
        runToEdge(edgeNum);
        checkOutput(tag, {30'd0, oHs, oVs}, {30'd0, expSync});
    endtask

    int           barEdge [8] = '{1, 321, 641, 961, 1281, 1601, 1921, 2241};
    logic [11:0]  barRgb  [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                  12'hF0F, 12'hF00, 12'h00F, 12'h000};

    initial begin
        checkCount = 0;
        errorCount = 0;
        curEdge    = 0;
        iRstN      = 1'b1;
        #1;
        applyStimulus(10);

        checkRgb("first_rgb", 1, 12'hFFF);
        checkSync("first_sync", 1, 2'b11);
        checkRgb("edge100", 100, 12'hFFF);

        // Short pulse between edges; the 1015 edge must act as the first edge again.
        #4;
        applyStimulus(2);
        checkRgb("pulse_rgb", 1, 12'hFFF);
        checkSync("pulse_sync", 1, 2'b11);

        checkRgb("bar0_last", 320, 12'hFFF);
        for (int b = 0; b < 8; b++)
            checkRgb($sformatf("bar%0d", b), barEdge[b], barRgb[b]);
        checkRgb("blank_start", 2561, 12'h000);
        checkSync("hs_before", 2624, 2'b11);
        checkSync("hs_low", 2625, 2'b01);
        checkSync("hs_low_end", 3008, 2'b01);
        checkSync("hs_high", 3009, 2'b11);
        checkRgb("blank_end", 3200, 12'h000);
        checkRgb("line1_start", 3201, 12'hFFF);
        checkSync("hs_line1_before", 5824, 2'b11);
        checkSync("hs_line1_low", 5825, 2'b01);

        checkRgb("line3_bar1", 9921, 12'hFF0);
        checkRgb("line4_start", 12801, 12'h000);
        checkRgb("line4_bar1", 13121, 12'h000);
        checkSync("line4_hs_low", 15425, 2'b01);

        checkSync("vs_before", 19200, 2'b11);
        checkSync("vs_low", 19201, 2'b10);
        checkSync("vs_low_end", 25600, 2'b10);
        checkSync("vs_high", 25601, 2'b11);

        checkRgb("frame_end", 32000, 12'h000);
        checkRgb("frame1_start", 32001, 12'hFFF);
        checkRgb("frame1_bar1", 32321, 12'hFF0);
        checkSync("frame1_vs_low", 51201, 2'b10);

        // Mid-frame reset during vertical sync must restart from pixel (0,0).
        #4;
        applyStimulus(2);
        checkRgb("restart_rgb", 1, 12'hFFF);
        checkSync("restart_sync", 1, 2'b11);
        checkRgb("restart_bar1", 321, 12'hFF0);
        checkSync("restart_hs_low", 2625, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
